// File: rtl/sram_controller.sv
// Sequencer between the eLC-3 memory interface and a 16-bit asynchronous SRAM.
// Turns a one-cycle request into a registered CE/OE/WE/LB/UB/ADDR/DQ sequence and pulses Ready on completion.
module sram_controller #(
    parameter int unsigned ReadWait  = 1,
    parameter int unsigned WriteWait = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        RW,
    input  logic [1:0]  ByteEn,
    input  logic [19:0] Addr,
    input  logic [15:0] WData,
    output logic [15:0] RData,
    output logic        Ready,
    output logic        Busy,
    output logic        CE,
    output logic        OE,
    output logic        WE,
    output logic        LB,
    output logic        UB,
    output logic [19:0] ADDR,
    inout  wire  [15:0] DQ
);

    if ((ReadWait > 32'd15) || (WriteWait > 32'd15)) begin : g_wait_range
        $error("sram_controller: ReadWait and WriteWait must be in 0..15");
    end

    localparam logic [3:0] READ_WAIT_C  = 4'(ReadWait);
    localparam logic [3:0] WRITE_WAIT_C = 4'(WriteWait);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic        accept_s;
    logic        capture_s;
    logic [1:0]  be_r;
    logic [1:0]  lane_be_s;
    logic [15:0] wdata_r;
    logic [15:0] rdata_r;
    logic [15:0] rdata_cap_s;
    logic [19:0] addr_r;

    logic ce_r, oe_r, we_r, lb_r, ub_r, dq_oe_r, ready_r, busy_r;
    logic ce_nxt_s, oe_nxt_s, we_nxt_s, lb_nxt_s, ub_nxt_s, dq_oe_nxt_s, ready_nxt_s, busy_nxt_s;

    // Next-state and wait-counter logic; the counter counts down to zero inside RD and WR_PULSE.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Req) begin
                    accept_s = 1'b1;
                    if (ByteEn == 2'b00) begin
                        state_nxt_s = ST_DONE;
                    end else if (RW) begin
                        state_nxt_s = ST_WR_SETUP;
                    end else begin
                        state_nxt_s = ST_RD;
                        cnt_nxt_s   = READ_WAIT_C;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_WR_SETUP: begin
                state_nxt_s = ST_WR_PULSE;
                cnt_nxt_s   = WRITE_WAIT_C;
            end
            ST_WR_PULSE: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_WR_HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_WR_HOLD: state_nxt_s = ST_DONE;
            ST_DONE:    state_nxt_s = ST_IDLE;
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Strobe values for the state being entered, so the registered pins line up with the state.
    always_comb begin
        ce_nxt_s    = 1'b1;
        oe_nxt_s    = 1'b1;
        we_nxt_s    = 1'b1;
        lb_nxt_s    = 1'b1;
        ub_nxt_s    = 1'b1;
        dq_oe_nxt_s = 1'b0;
        ready_nxt_s = 1'b0;
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        if (accept_s) begin
            lane_be_s = ByteEn;
        end else begin
            lane_be_s = be_r;
        end
        case (state_nxt_s)
            ST_RD: begin
                ce_nxt_s = 1'b0;
                oe_nxt_s = 1'b0;
                ub_nxt_s = ~lane_be_s[1];
                lb_nxt_s = ~lane_be_s[0];
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_nxt_s    = 1'b0;
                ub_nxt_s    = ~lane_be_s[1];
                lb_nxt_s    = ~lane_be_s[0];
                dq_oe_nxt_s = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_nxt_s    = 1'b0;
                we_nxt_s    = 1'b0;
                ub_nxt_s    = ~lane_be_s[1];
                lb_nxt_s    = ~lane_be_s[0];
                dq_oe_nxt_s = 1'b1;
            end
            ST_DONE: ready_nxt_s = 1'b1;
            ST_IDLE: ready_nxt_s = 1'b0;
            default: ready_nxt_s = 1'b0;
        endcase
    end

    // Read capture: disabled byte lanes load zero rather than bus noise.
    always_comb begin
        if (be_r[1]) begin
            rdata_cap_s[15:8] = DQ[15:8];
        end else begin
            rdata_cap_s[15:8] = 8'h00;
        end
        if (be_r[0]) begin
            rdata_cap_s[7:0] = DQ[7:0];
        end else begin
            rdata_cap_s[7:0] = 8'h00;
        end
    end

    // FSM state and wait counter.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Latched request fields and registered SRAM-side outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            be_r    <= 2'b00;
            wdata_r <= 16'h0000;
            addr_r  <= 20'h00000;
            rdata_r <= 16'h0000;
            ce_r    <= 1'b1;
            oe_r    <= 1'b1;
            we_r    <= 1'b1;
            lb_r    <= 1'b1;
            ub_r    <= 1'b1;
            dq_oe_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                be_r    <= ByteEn;
                wdata_r <= WData;
                // A no-lane request never reaches the SRAM, so ADDR keeps its last value.
                if (ByteEn != 2'b00) begin
                    addr_r <= Addr;
                end
            end
            if (capture_s) begin
                rdata_r <= rdata_cap_s;
            end
            ce_r    <= ce_nxt_s;
            oe_r    <= oe_nxt_s;
            we_r    <= we_nxt_s;
            lb_r    <= lb_nxt_s;
            ub_r    <= ub_nxt_s;
            dq_oe_r <= dq_oe_nxt_s;
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign DQ    = dq_oe_r ? wdata_r : 16'hzzzz;
    assign RData = rdata_r;
    assign Ready = ready_r;
    assign Busy  = busy_r;
    assign CE    = ce_r;
    assign OE    = oe_r;
    assign WE    = we_r;
    assign LB    = lb_r;
    assign UB    = ub_r;
    assign ADDR  = addr_r;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM device model on DQ, directed scenarios plus random accesses
// checked against an array-based memory model and latency formulas.
module tb_sram_controller;

    localparam int          READ_WAIT  = 1;
    localparam int          WRITE_WAIT = 1;
    localparam logic [15:0] KEEPER     = 16'h5A5A;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req;
    logic        RW;
    logic [1:0]  ByteEn;
    logic [19:0] Addr;
    logic [15:0] WData;
    logic [15:0] RData;
    logic        Ready;
    logic        Busy;
    logic        CE, OE, WE, LB, UB;
    logic [19:0] ADDR;
    wire  [15:0] DQ;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ref_mem [0:255];
    logic [15:0] last_rd;
    logic [15:0] sram [0:255];
    logic [15:0] sram_q;
    bit          sram_loaded;

    sram_controller #(.ReadWait(READ_WAIT), .WriteWait(WRITE_WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .RW(RW), .ByteEn(ByteEn),
        .Addr(Addr), .WData(WData), .RData(RData), .Ready(Ready), .Busy(Busy),
        .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB), .ADDR(ADDR), .DQ(DQ)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] init_word(input int i);
        if (i == 5) return 16'hABCD;
        else if (i == 9) return 16'h1234;
        else return 16'(i * 40503) ^ 16'h3C3C;
    endfunction

    // Asynchronous SRAM stand-in: reads while CE/OE low, byte writes for each WE-low cycle.
    assign sram_q = sram[ADDR[7:0]];
    assign DQ = (!CE && !OE && WE) ? sram_q : 16'hzzzz;
    // Keeper stand-in so a deselected, undriven bus reads a known value.
    assign DQ = CE ? KEEPER : 16'hzzzz;

    always @(posedge Clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
            sram_loaded <= 1'b1;
        end else if (!CE && !WE) begin
            if (!UB) sram[ADDR[7:0]][15:8] <= DQ[15:8];
            if (!LB) sram[ADDR[7:0]][7:0]  <= DQ[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request, monitored cycle by cycle until Ready or a 40-cycle budget.
    task automatic do_access(input logic rw, input logic [1:0] be, input logic [19:0] a,
                             input logic [15:0] wd, input bit chk_rdata);
        int lat_exp, ce_exp, oe_exp, we_exp;
        int lat, ce_n, oe_n, we_n, ovl, bad_ctl, bad_bus;
        logic busy1;
        logic [15:0] rd_exp;

        lat_exp = (be == 2'b00) ? 1 : (rw ? WRITE_WAIT + 4 : READ_WAIT + 2);
        ce_exp  = (be == 2'b00) ? 0 : (rw ? WRITE_WAIT + 3 : READ_WAIT + 1);
        oe_exp  = (be != 2'b00 && !rw) ? READ_WAIT + 1 : 0;
        we_exp  = (be != 2'b00 && rw) ? WRITE_WAIT + 1 : 0;
        rd_exp  = last_rd;
        if (be != 2'b00 && !rw) begin
            rd_exp[15:8] = be[1] ? ref_mem[a[7:0]][15:8] : 8'h00;
            rd_exp[7:0]  = be[0] ? ref_mem[a[7:0]][7:0]  : 8'h00;
            last_rd = rd_exp;
        end else if (be != 2'b00) begin
            if (be[1]) ref_mem[a[7:0]][15:8] = wd[15:8];
            if (be[0]) ref_mem[a[7:0]][7:0]  = wd[7:0];
        end

        @(negedge Clk);
        Req = 1'b1; RW = rw; ByteEn = be; Addr = a; WData = wd;
        @(posedge Clk);
        #1;
        Req = 1'b0; RW = 1'($urandom); ByteEn = 2'($urandom);
        Addr = 20'($urandom); WData = 16'($urandom);

        lat = 0; ce_n = 0; oe_n = 0; we_n = 0; ovl = 0; bad_ctl = 0; bad_bus = 0; busy1 = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge Clk);
            if (k == 1) busy1 = Busy;
            if (!CE) begin
                ce_n++;
                if (ADDR !== a || UB !== ~be[1] || LB !== ~be[0]) bad_ctl++;
                if (rw && DQ !== wd) bad_bus++;
            end
            if (!OE) oe_n++;
            if (!WE) we_n++;
            if (!OE && !WE) ovl++;
            if (Ready === 1'b1) lat = k;
        end
        check("latency", lat, lat_exp);
        check("busy_first", busy1, 1'b1);
        check("ce_cycles", ce_n, ce_exp);
        check("oe_cycles", oe_n, oe_exp);
        check("we_cycles", we_n, we_exp);
        check("oe_we_overlap", ovl, 0);
        check("addr_lanes", bad_ctl, 0);
        check("write_bus", bad_bus, 0);
        if (chk_rdata) check("rdata", RData, rd_exp);
        @(negedge Clk);
        check("ready_pulse", Ready, 1'b0);
        check("idle_busy", Busy, 1'b0);
        check("idle_bus", DQ, KEEPER);
    endtask

    initial begin
        int n;
        int pos [0:3];
        int exp_pos [$];
        logic [15:0] old_word;
        logic [15:0] seen;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        last_rd = 16'h0000;

        // Reset held two cycles with a pending request.
        Reset = 1'b0; Req = 1'b1; RW = 1'b0; ByteEn = 2'b11; Addr = 20'd5; WData = 16'h0000;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_strobes", {CE, OE, WE, LB, UB}, 5'b11111);
        check("rst_busy", Busy, 1'b0);
        check("rst_ready", Ready, 1'b0);
        check("rst_rdata", RData, 16'h0000);
        check("rst_addr", ADDR, 20'h00000);
        check("rst_bus", DQ, KEEPER);
        Reset = 1'b1; Req = 1'b0;

        do_access(1'b0, 2'b11, 20'd5, 16'h0000, 1'b1);
        do_access(1'b1, 2'b10, 20'd9, 16'hFF00, 1'b1);
        do_access(1'b0, 2'b11, 20'd9, 16'h0000, 1'b1);
        check("word_after_byte_write", last_rd, 16'hFF34);
        do_access(1'b0, 2'b00, 20'd5, 16'h0000, 1'b1);

        // Req held for 10 edges: one access per latency+1 cycles, the rest ignored.
        for (int t = 0; t <= 9; t += READ_WAIT + 3) exp_pos.push_back(t + READ_WAIT + 2);
        @(negedge Clk);
        Req = 1'b1; RW = 1'b0; ByteEn = 2'b11; Addr = 20'd5;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == 10) Req = 1'b0;
            @(negedge Clk);
            if (Ready === 1'b1) begin
                if (n < 4) pos[n] = k + 1;
                n++;
            end
        end
        check("b2b_ready_count", n, exp_pos.size());
        for (int i = 0; i < exp_pos.size() && i < n && i < 4; i++) check("b2b_ready_pos", pos[i], exp_pos[i]);
        check("b2b_rdata", RData, ref_mem[5]);
        last_rd = ref_mem[5];

        for (int r = 0; r < 24; r++) begin
            do_access(1'($urandom), 2'($urandom), 20'($urandom_range(0, 15)), 16'($urandom), 1'b1);
        end

        // Reset during WR_PULSE: controls must drop back at once.
        old_word = ref_mem[200];
        @(negedge Clk);
        Req = 1'b1; RW = 1'b1; ByteEn = 2'b11; Addr = 20'd200; WData = 16'h0F0F;
        @(posedge Clk);
        #1;
        Req = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check("midwr_we_low", WE, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);
        check("midwr_strobes", {CE, WE, OE}, 3'b111);
        check("midwr_busy", Busy, 1'b0);
        check("midwr_ready", Ready, 1'b0);
        check("midwr_bus", DQ, KEEPER);
        Reset = 1'b1;
        do_access(1'b0, 2'b11, 20'd200, 16'h0000, 1'b0);
        seen = RData;
        check("midwr_data_old_or_new", (seen === old_word) || (seen === 16'h0F0F), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
